// File: rtl/uart_bus_ctrl_if.sv
// uart_bus_ctrl_if: system-bus slave port bundle for the uart controller
interface uart_bus_ctrl_if;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [1:0]  sel_i;
   logic        rd_i;
   logic        we_i;
   logic        ack_o;
   modport master (output addr_i, data_i, sel_i, rd_i, we_i, input data_o, ack_o);
   modport slave  (input addr_i, data_i, sel_i, rd_i, we_i, output data_o, ack_o);
endinterface

// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: bus-slave register front end with TX/RX FIFOs and send/sent sequencing for the uart core
module uart_bus_ctrl #(
   parameter int FIFO_AW = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   uart_bus_ctrl_if.slave        bus,
   output logic [7:0]            data_in,
   output logic                  data_send,
   input  logic                  data_sent,
   input  logic [7:0]            data_out,
   input  logic                  data_received,
   output logic                  interrupt
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW = FIFO_AW + 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   logic              ack_q, send_q, irq_q, rx_ovf_q, tx_ovf_q;
   logic              rx_ovf_d, tx_ovf_d, irq_d;
   logic [0:0]        state_q, state_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [7:0]        data_in_q, data_in_d;
   logic [31:0]       data_o_q, data_o_d, status, rdata;
   logic [7:0]        rx_mem_q [DEPTH];
   logic [7:0]        tx_mem_q [DEPTH];
   logic [FIFO_AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d, tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [CW-1:0]     rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic              acc, wr, rd, rx_full, tx_full, rx_avail, tx_idle;
   logic              rx_pop, rx_push, tx_push, tx_launch;
   logic [1:0]        reg_sel;
   logic              unused_bits;
   assign unused_bits = ^{bus.sel_i, bus.addr_i[31:4], bus.addr_i[1:0], bus.data_i[31:8]};
   assign acc       = (bus.rd_i | bus.we_i) & ~ack_q;
   assign wr        = acc & bus.we_i;
   assign rd        = acc & bus.rd_i & ~bus.we_i;
   assign reg_sel   = bus.addr_i[3:2];
   assign rx_full   = rx_cnt_q == CW'(DEPTH);
   assign tx_full   = tx_cnt_q == CW'(DEPTH);
   assign rx_avail  = rx_cnt_q != '0;
   assign tx_idle   = (tx_cnt_q == '0) && (state_q == IDLE);
   assign tx_launch = (state_q == IDLE) && (tx_cnt_q != '0);
   assign rx_pop    = rd && reg_sel == 2'd0 && rx_avail;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign rx_push   = data_received & (~rx_full | rx_pop);
   assign tx_push   = wr && reg_sel == 2'd0 && (!tx_full || tx_launch);
   assign status    = {11'b0, 5'(tx_cnt_q), 3'b0, 5'(rx_cnt_q), 3'b0,
                       tx_ovf_q, rx_ovf_q, tx_idle, tx_full, rx_avail};
   always_comb begin
      rdata     = reg_sel == 2'd0 ? (rx_avail ? {24'b0, rx_mem_q[rx_rp_q]} : 32'b0) :
                  reg_sel == 2'd1 ? status :
                  reg_sel == 2'd2 ? {30'b0, ctrl_q} : 32'b0;
      data_o_d  = rd ? rdata : 32'b0;
      rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_launch);
      rx_wp_d   = rx_wp_q + FIFO_AW'(rx_push);
      rx_rp_d   = rx_rp_q + FIFO_AW'(rx_pop);
      tx_wp_d   = tx_wp_q + FIFO_AW'(tx_push);
      tx_rp_d   = tx_rp_q + FIFO_AW'(tx_launch);
      rx_ovf_d  = (data_received & rx_full & ~rx_pop) |
                  (rx_ovf_q & ~(wr && reg_sel == 2'd1 && bus.data_i[3]));
      tx_ovf_d  = (wr && reg_sel == 2'd0 && tx_full && !tx_launch) |
                  (tx_ovf_q & ~(wr && reg_sel == 2'd1 && bus.data_i[4]));
      ctrl_d    = (wr && reg_sel == 2'd2) ? bus.data_i[1:0] : ctrl_q;
      state_d   = tx_launch ? BUSY : (state_q == BUSY && data_sent) ? IDLE : state_q;
      data_in_d = tx_launch ? tx_mem_q[tx_rp_q] : data_in_q;
      irq_d     = (ctrl_q[0] & rx_avail) | (ctrl_q[1] & tx_idle) | rx_ovf_q;
   end
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= data_out;
      if (tx_push) tx_mem_q[tx_wp_q] <= bus.data_i[7:0];
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ack_q     <= 1'b0;
         data_o_q  <= '0;
         send_q    <= 1'b0;
         data_in_q <= '0;
         irq_q     <= 1'b0;
         state_q   <= IDLE;
         ctrl_q    <= '0;
         rx_ovf_q  <= 1'b0;
         tx_ovf_q  <= 1'b0;
         rx_cnt_q  <= '0;
         tx_cnt_q  <= '0;
         rx_wp_q   <= '0;
         rx_rp_q   <= '0;
         tx_wp_q   <= '0;
         tx_rp_q   <= '0;
      end else begin
         ack_q     <= acc;
         data_o_q  <= data_o_d;
         send_q    <= tx_launch;
         data_in_q <= data_in_d;
         irq_q     <= irq_d;
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         rx_ovf_q  <= rx_ovf_d;
         tx_ovf_q  <= tx_ovf_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_wp_q   <= rx_wp_d;
         rx_rp_q   <= rx_rp_d;
         tx_wp_q   <= tx_wp_d;
         tx_rp_q   <= tx_rp_d;
      end
   end
   assign bus.ack_o  = ack_q;
   assign bus.data_o = data_o_q;
   assign data_send  = send_q;
   assign data_in    = data_in_q;
   assign interrupt  = irq_q;
endmodule

// File: tb/tb_uart_bus_ctrl.sv
// tb_uart_bus_ctrl: directed scoreboard bench for uart_bus_ctrl
module tb_uart_bus_ctrl;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic [7:0] data_in;
   logic data_send;
   logic data_sent = 1'b0;
   logic [7:0] data_out = 8'h00;
   logic data_received = 1'b0;
   logic interrupt;
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [7:0] tx_q[$];
   logic [31:0] tmp;
   uart_bus_ctrl_if bus ();
   uart_bus_ctrl #(.FIFO_AW(4)) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .data_in(data_in), .data_send(data_send), .data_sent(data_sent),
      .data_out(data_out), .data_received(data_received), .interrupt(interrupt)
   );
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] st(input int rxc, input int txc, input bit idle,
                                      input bit rovf, input bit tovf);
      logic [4:0] r = 5'(rxc);
      logic [4:0] t = 5'(txc);
      return {11'b0, t, 3'b0, r, 3'b0, tovf, rovf, idle, txc == 16, rxc != 0};
   endfunction
   task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string tag);
      bit got = 1'b0;
      exp_q.push_back(e);
      bus.addr_i = a;
      bus.rd_i = 1'b1;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         got = bus.ack_o;
      end
      bus.rd_i = 1'b0;
      tmp = exp_q.pop_front();
      if (got) chk(tag, bus.data_o, tmp);
      else chk({tag, "_ack"}, 32'(bus.ack_o), 32'd1);
   endtask
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bit got = 1'b0;
      bus.addr_i = a;
      bus.data_i = d;
      bus.we_i = 1'b1;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         got = bus.ack_o;
      end
      bus.we_i = 1'b0;
      if (!got) chk("write_ack", 32'(bus.ack_o), 32'd1);
   endtask
   task automatic wait_send(input string tag);
      bit got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         got = data_send;
      end
      if (got) begin
         chk(tag, 32'(data_in), 32'(tx_q.pop_front()));
         tick();
         chk({tag, "_pulse"}, 32'(data_send), 32'd0);
      end else chk({tag, "_send"}, 32'(data_send), 32'd1);
   endtask
   task automatic pulse_sent();
      data_sent = 1'b1;
      tick();
      data_sent = 1'b0;
   endtask
   initial begin
      bus.addr_i = 32'd4;
      bus.data_i = '0;
      bus.sel_i = 2'b11;
      bus.rd_i = 1'b1;
      bus.we_i = 1'b0;
      tick();
      tick();
      chk("rst_ack", 32'(bus.ack_o), 32'd0);
      chk("rst_irq", 32'(interrupt), 32'd0);
      chk("rst_send", 32'(data_send), 32'd0);
      chk("rst_din", 32'(data_in), 32'd0);
      bus.rd_i = 1'b0;
      rstn = 1'b1;
      tick();
      bus_read(32'd4, st(0, 0, 1, 0, 0), "rst_status");
      // TX sequencing
      tx_q.push_back(8'h41);
      bus_write(32'd0, 32'h41);
      wait_send("tx_first");
      tx_q.push_back(8'h42);
      bus_write(32'd0, 32'h42);
      bus_read(32'd4, st(0, 1, 0, 0, 0), "tx_busy_status");
      pulse_sent();
      chk("tx_gap", 32'(data_send), 32'd0);
      wait_send("tx_second");
      bus_read(32'd4, st(0, 0, 0, 0, 0), "tx_inflight_status");
      pulse_sent();
      bus_read(32'd4, st(0, 0, 1, 0, 0), "tx_idle_status");
      // RX overflow
      for (int i = 0; i < 17; i++) begin
         data_out = 8'(i);
         data_received = 1'b1;
         tick();
      end
      data_received = 1'b0;
      bus_read(32'd4, st(16, 0, 1, 1, 0), "rx_ovf_status");
      for (int i = 0; i < 16; i++) bus_read(32'd0, 32'(i), "rx_data");
      bus_read(32'd0, 32'd0, "rx_empty_read");
      bus_write(32'd4, 32'h8);
      bus_read(32'd4, st(0, 0, 1, 0, 0), "rx_ovf_clear");
      // RX push and pop in the same cycle while full
      for (int i = 0; i < 16; i++) begin
         data_out = 8'h50 + 8'(i);
         data_received = 1'b1;
         tick();
      end
      data_received = 1'b0;
      tick();
      exp_q.push_back(32'h50);
      data_out = 8'hAA;
      data_received = 1'b1;
      bus.addr_i = 32'd0;
      bus.rd_i = 1'b1;
      tick();
      data_received = 1'b0;
      bus.rd_i = 1'b0;
      chk("sim_ack", 32'(bus.ack_o), 32'd1);
      tmp = exp_q.pop_front();
      chk("sim_oldest", bus.data_o, tmp);
      bus_read(32'd4, st(16, 0, 1, 0, 0), "sim_status");
      for (int i = 1; i < 16; i++) bus_read(32'd0, 32'h50 + 32'(i), "sim_data");
      bus_read(32'd0, 32'hAA, "sim_last");
      // TX full with the core stalled
      for (int i = 0; i < 17; i++) bus_write(32'd0, 32'h60 + 32'(i));
      bus_read(32'd4, st(0, 16, 0, 0, 0), "txfull_status");
      chk("txfull_din", 32'(data_in), 32'h60);
      bus_write(32'd0, 32'h99);
      bus_read(32'd4, st(0, 16, 0, 0, 1), "txovf_status");
      bus_write(32'd4, 32'h10);
      bus_read(32'd4, st(0, 16, 0, 0, 0), "txovf_clear");
      // reset abandons the in-flight frame
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      chk("rst2_din", 32'(data_in), 32'd0);
      pulse_sent();
      chk("rst2_send", 32'(data_send), 32'd0);
      tick();
      chk("rst2_send2", 32'(data_send), 32'd0);
      bus_read(32'd4, st(0, 0, 1, 0, 0), "rst2_status");
      // CTRL, reserved, interrupt timing
      bus_write(32'd8, 32'hFFFF_FFFD);
      bus_read(32'd8, 32'd1, "ctrl_read");
      bus_write(32'd12, 32'hFFFF_FFFF);
      bus_read(32'd12, 32'd0, "rsvd_read");
      data_out = 8'h77;
      data_received = 1'b1;
      tick();
      data_received = 1'b0;
      chk("irq_early", 32'(interrupt), 32'd0);
      tick();
      chk("irq_rise", 32'(interrupt), 32'd1);
      bus_read(32'd0, 32'h77, "irq_data");
      chk("irq_hold", 32'(interrupt), 32'd1);
      tick();
      chk("irq_fall", 32'(interrupt), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
